// File: rtl/vme_ram_sampler_ctrl_if.sv
// Sampler control bus: spill gate and per-spill configuration in, RAM write
// strobe/address and per-spill status out.
// master: spill-gate / VME side (drives live and config, observes status).
// slave : vme_ram_sampler_ctrl (consumes live and config, drives strobe and status).
interface vme_ram_sampler_ctrl_if #(
    parameter int AW = 12,
    parameter int IW = 17
);
    logic          live;        // spill gate, synchronous to clk
    logic [IW-1:0] interval;    // cycles per sample (0 behaves as 1)
    logic [IW-1:0] holdoff;     // cycles to wait after spill start
    logic          wrap_mode;   // 0 = stop at full, 1 = circular
    logic          wr_ena;      // one-cycle RAM write strobe
    logic [AW-1:0] wr_addr;     // RAM address, valid with wr_ena
    logic [AW:0]   n_samples;   // writes this spill, saturating at 2**AW
    logic          full;        // 2**AW writes done this spill
    logic          overflow;    // sample dropped or overwritten this spill
    logic          spill_done;  // one-cycle pulse at spill end

    modport master (
        output live, interval, holdoff, wrap_mode,
        input  wr_ena, wr_addr, n_samples, full, overflow, spill_done
    );

    modport slave (
        input  live, interval, holdoff, wrap_mode,
        output wr_ena, wr_addr, n_samples, full, overflow, spill_done
    );
endinterface

// File: rtl/vme_ram_sampler_ctrl.sv
// Periodic RAM sampler control: after a holdoff, slices each live spill into
// interval-long bins and issues one RAM write per bin (stop-at-full or wrap).
// Latency: first strobe at E+H+I+1 (H>0) or E+I+1 (H=0), E = spill-start cycle.
// Ports: clk, reset (sync, active-high), smp_if (slave modport: live/interval/
// holdoff/wrap_mode in; wr_ena/wr_addr/n_samples/full/overflow/spill_done out).
// No backpressure: the RAM is assumed to accept every strobe.
module vme_ram_sampler_ctrl #(
    parameter int AW = 12,
    parameter int IW = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    vme_ram_sampler_ctrl_if.slave smp_if
);

    localparam logic [AW:0]   DEPTH    = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] LAST_PTR = {AW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLDOFF,
        ST_SAMPLE,
        ST_FULL
    } state_t;

    state_t        state_q,      state_d;
    logic          live_dly_q,   live_dly_d;
    logic [IW-1:0] timer_q,      timer_d;
    logic [IW-1:0] ivl_q,        ivl_d;
    logic [IW-1:0] hold_q,       hold_d;
    logic          wrap_q,       wrap_d;
    logic [AW-1:0] ptr_q,        ptr_d;
    logic [AW-1:0] wr_addr_q,    wr_addr_d;
    logic [AW:0]   n_samples_q,  n_samples_d;
    logic          full_q,       full_d;
    logic          overflow_q,   overflow_d;
    logic          wr_ena_q,     wr_ena_d;
    logic          spill_done_q, spill_done_d;

    logic          spill_start;
    logic          spill_end;
    logic          ivl_expiry;
    logic          hold_expiry;
    logic [IW-1:0] timer_inc;

    // A rise is honoured from any state; a fall only ends an active spill.
    assign spill_start = smp_if.live & ~live_dly_q;
    assign spill_end   = ~smp_if.live & live_dly_q & (state_q != ST_IDLE);
    assign ivl_expiry  = (timer_q == ivl_q - IW'(1));
    assign hold_expiry = (timer_q == hold_q - IW'(1));
    assign timer_inc   = timer_q + IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            live_dly_q   <= 1'b1;   // ignore a spill already running at reset
            timer_q      <= '0;
            ivl_q        <= IW'(1);
            hold_q       <= '0;
            wrap_q       <= 1'b0;
            ptr_q        <= '0;
            wr_addr_q    <= '0;
            n_samples_q  <= '0;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ena_q     <= 1'b0;
            spill_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            live_dly_q   <= live_dly_d;
            timer_q      <= timer_d;
            ivl_q        <= ivl_d;
            hold_q       <= hold_d;
            wrap_q       <= wrap_d;
            ptr_q        <= ptr_d;
            wr_addr_q    <= wr_addr_d;
            n_samples_q  <= n_samples_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
            wr_ena_q     <= wr_ena_d;
            spill_done_q <= spill_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        live_dly_d   = smp_if.live;
        timer_d      = timer_q;
        ivl_d        = ivl_q;
        hold_d       = hold_q;
        wrap_d       = wrap_q;
        ptr_d        = ptr_q;
        wr_addr_d    = wr_addr_q;
        n_samples_d  = n_samples_q;
        full_d       = full_q;
        overflow_d   = overflow_q;
        wr_ena_d     = 1'b0;
        spill_done_d = 1'b0;

        if (spill_start) begin
            // Configuration is frozen here for the whole spill.
            ivl_d       = (smp_if.interval == '0) ? IW'(1) : smp_if.interval;
            hold_d      = smp_if.holdoff;
            wrap_d      = smp_if.wrap_mode;
            timer_d     = '0;
            ptr_d       = '0;
            wr_addr_d   = '0;
            n_samples_d = '0;
            full_d      = 1'b0;
            overflow_d  = 1'b0;
            state_d     = (smp_if.holdoff != '0) ? ST_HOLDOFF : ST_SAMPLE;
        end else if (spill_end) begin
            // Takes priority over a coinciding expiry: that sample is lost.
            // Status registers are left untouched for readout.
            state_d      = ST_IDLE;
            timer_d      = '0;
            spill_done_d = 1'b1;
        end else begin
            case (state_q)
                ST_HOLDOFF: begin
                    if (hold_expiry) begin
                        state_d = ST_SAMPLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                ST_SAMPLE: begin
                    if (ivl_expiry) begin
                        timer_d   = '0;
                        wr_ena_d  = 1'b1;
                        wr_addr_d = ptr_q;
                        ptr_d     = ptr_q + AW'(1);   // wraps naturally to 0
                        if (n_samples_q != DEPTH) begin
                            n_samples_d = n_samples_q + (AW+1)'(1);
                        end
                        // Any write after the buffer filled replaces old data.
                        if (full_q) begin
                            overflow_d = 1'b1;
                        end
                        if (ptr_q == LAST_PTR) begin
                            full_d = 1'b1;
                            if (!wrap_q) begin
                                state_d = ST_FULL;
                            end
                        end
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                ST_FULL: begin
                    // Bins keep ticking so each dropped sample is noticed.
                    if (ivl_expiry) begin
                        timer_d    = '0;
                        overflow_d = 1'b1;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
                default: begin
                    timer_d = '0;
                end
            endcase
        end
    end

    // Gate the strobe with reset so a pending write never leaks into a reset cycle.
    assign smp_if.wr_ena     = wr_ena_q & ~reset;
    assign smp_if.wr_addr    = wr_addr_q;
    assign smp_if.n_samples  = n_samples_q;
    assign smp_if.full       = full_q;
    assign smp_if.overflow   = overflow_q;
    assign smp_if.spill_done = spill_done_q;

endmodule
